// File: rtl/me_pkg.sv
// me_pkg: shared constants, FSM state encoding and the search-window
// address helper for the motion-estimation sequencer.
package me_pkg;

    localparam int NPE        = 16;              // PEs = horizontal candidate offsets
    localparam int NROW       = 16;              // vertical candidate offsets
    localparam int BLK_PIX    = 256;             // pixels per 16x16 reference block
    localparam int SWEEP_PIX  = NROW * BLK_PIX;  // RUN cycles seen by one PE
    localparam int SWEEP_LAST = SWEEP_PIX + NPE - 1; // 4111: PE15's final result
    localparam int ADDR_LAST  = SWEEP_PIX - 1;   // addresses freeze after this count

    localparam int CNT_W = 13;                   // holds 0..4111
    localparam int AR_W  = 8;                    // reference block address
    localparam int AS_W  = 10;                   // search window address (32-wide rows)
    localparam int VEC_W = 4;                    // candidate vector component

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } me_state_e;

    // Search-window address for sweep position c: row = candidate y + pixel row,
    // half-select bit picks columns 0..15 (bus S1) or 16..31 (bus S2).
    function automatic logic [AS_W-1:0] win_addr(input logic [11:0] c, input logic hi);
        logic [4:0] row;
        row = {1'b0, c[11:8]} + {1'b0, c[7:4]};
        return {row, hi, c[3:0]};
    endfunction

endpackage

// File: rtl/me_if.sv
// me_if: sequencer-facing bundle. master = the sequencer (me_control),
// slave = the PE array / comparator side. Optional abort input when
// ME_ABORT_EN is defined.
interface me_if;
    import me_pkg::*;

    logic              start;
`ifdef ME_ABORT_EN
    logic              abort;
`endif
    logic              busy;
    logic              done;
    logic [AR_W-1:0]   AddressR;
    logic [AS_W-1:0]   AddressS1;
    logic [AS_W-1:0]   AddressS2;
    logic [NPE-1:0]    S1S2mux;
    logic [NPE-1:0]    newDist;
    logic [NPE-1:0]    PEready;
    logic              CompStart;
    logic [VEC_W-1:0]  vectorX;
    logic [VEC_W-1:0]  vectorY;

    modport master (
        input  start,
`ifdef ME_ABORT_EN
        input  abort,
`endif
        output busy, done, AddressR, AddressS1, AddressS2, S1S2mux,
               newDist, PEready, CompStart, vectorX, vectorY
    );

    modport slave (
        output start,
`ifdef ME_ABORT_EN
        output abort,
`endif
        input  busy, done, AddressR, AddressS1, AddressS2, S1S2mux,
               newDist, PEready, CompStart, vectorX, vectorY
    );

endinterface

// File: rtl/me_addr_gen.sv
// me_addr_gen: pure decode of the sweep count into reference/search memory
// addresses and the per-PE bus select. All outputs are 0 when disabled (IDLE).
module me_addr_gen
    import me_pkg::*;
(
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_count,
    output logic [AR_W-1:0]  o_addr_r,
    output logic [AS_W-1:0]  o_addr_s1,
    output logic [AS_W-1:0]  o_addr_s2,
    output logic [NPE-1:0]   o_s1s2mux
);

    logic [11:0] w_c;   // count clamped so the search addresses freeze at 4095
    logic [11:0] w_t;   // bus S2 lags bus S1 by 16 pixels

    // Address and bus-select decode from the (clamped) sweep position.
    always_comb begin
        w_c       = (i_count > CNT_W'(ADDR_LAST)) ? 12'hFFF : i_count[11:0];
        w_t       = w_c - 12'd16;
        o_addr_r  = '0;
        o_addr_s1 = '0;
        o_addr_s2 = '0;
        o_s1s2mux = '0;
        if (i_en) begin
            o_addr_r  = i_count[AR_W-1:0];
            o_addr_s1 = win_addr(w_c, 1'b0);
            o_addr_s2 = (w_c < 12'd16) ? '0 : win_addr(w_t, 1'b1);
            for (int i = 0; i < NPE; i++)
                o_s1s2mux[i] = (4'(i) <= i_count[3:0]);
        end
    end

endmodule

// File: rtl/me_control.sv
// me_control: full-search motion-estimation sequencer. Sweeps 16x16
// candidates over a 16-PE systolic array: IDLE -> RUN (4112 cycles) -> DONE.
// Optional feature macro ME_ABORT_EN adds an abort input that drops RUN to
// IDLE on the next cycle without a done pulse.
module me_control
    import me_pkg::*;
(
    input  logic i_clock,
    input  logic i_reset,
    me_if.master bus
);

    me_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic             w_abort;
    logic             w_run;

    logic [NPE-1:0]             w_nd;
    logic [NPE-1:0]             w_rdy;
    logic [NPE-1:0][VEC_W-1:0]  w_vy;
    logic [VEC_W-1:0]           w_vec_x;
    logic [VEC_W-1:0]           w_vec_y;

`ifdef ME_ABORT_EN
    assign w_abort = bus.abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_run = (r_state == ST_RUN);

    // State and sweep counter registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next state; count is 0 outside RUN and holds at the last value into DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            ST_IDLE: begin
                w_count_nxt = '0;
                if (bus.start) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end else if (r_count == CNT_W'(SWEEP_LAST)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    // Per-PE decode: PE g runs g cycles behind PE0 (local count ci = count - g).
    for (genvar g = 0; g < NPE; g++) begin : g_pe
        logic [CNT_W-1:0] w_ci;
        logic             w_started;
        logic             w_blk_edge;
        assign w_ci       = r_count - CNT_W'(g);
        assign w_started  = (r_count >= CNT_W'(g));
        assign w_blk_edge = (w_ci[7:0] == 8'd0);
        assign w_nd[g]    = w_run && w_started && w_blk_edge &&
                            (w_ci <= CNT_W'(SWEEP_PIX - 1));
        assign w_rdy[g]   = w_run && w_started && w_blk_edge &&
                            (w_ci >= CNT_W'(BLK_PIX)) && (w_ci <= CNT_W'(SWEEP_PIX));
        // Result completes one block after the candidate started, hence -1.
        assign w_vy[g]    = w_ci[11:8] - 4'd1;
    end

    // Vector of the PE reporting this cycle; stagger makes PEready one-hot.
    always_comb begin
        w_vec_x = '0;
        w_vec_y = '0;
        for (int i = 0; i < NPE; i++) begin
            if (w_rdy[i]) begin
                w_vec_x = VEC_W'(i);
                w_vec_y = w_vy[i];
            end
        end
    end

    me_addr_gen u_addr_gen (
        .i_en      (r_state != ST_IDLE),
        .i_count   (r_count),
        .o_addr_r  (bus.AddressR),
        .o_addr_s1 (bus.AddressS1),
        .o_addr_s2 (bus.AddressS2),
        .o_s1s2mux (bus.S1S2mux)
    );

    assign bus.busy      = w_run;
    assign bus.done      = (r_state == ST_DONE);
    assign bus.newDist   = w_nd;
    assign bus.PEready   = w_rdy;
    assign bus.vectorX   = w_vec_x;
    assign bus.vectorY   = w_vec_y;
    // First result (count 256) loads the comparator; every later one compares.
    assign bus.CompStart = (w_run && (r_count > CNT_W'(BLK_PIX))) || (r_state == ST_DONE);

endmodule

// File: tb/tb_me_control.sv
// tb_me_control: randomized self-checking bench for me_control. The reference
// model is an event table of candidate starts/results plus arithmetic search
// window addresses. Define ME_ABORT_EN to also exercise abort.
module tb_me_control;
    import me_pkg::*;

    typedef logic [86:0] vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    logic [15:0] nd_tab  [0:4111];
    int          rdy_pe  [0:4111];
    int          rdy_y   [0:4111];

    always #5 clock = ~clock;

    me_if bus();

    me_control dut (
        .i_clock (clock),
        .i_reset (reset),
        .bus     (bus)
    );

    // Candidate (x,y) starts at count x+256*y on PE x and finishes 256 later.
    function automatic void build_tables();
        for (int n = 0; n < 4112; n++) begin
            nd_tab[n] = '0;
            rdy_pe[n] = -1;
            rdy_y[n]  = 0;
        end
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) begin
                nd_tab[x + 256*y][x] = 1'b1;
                rdy_pe[x + 256*(y+1)] = x;
                rdy_y[x + 256*(y+1)]  = y;
            end
    endfunction

    function automatic int win(input int c, input int half);
        return ((c / 256) + ((c / 16) % 16)) * 32 + half * 16 + (c % 16);
    endfunction

    // Expected outputs during RUN at sweep count n.
    function automatic vec_t model(input int n);
        int c, s1, s2, mux, pe;
        logic [15:0] rdy;
        logic [3:0]  vx, vy;
        c   = (n > 4095) ? 4095 : n;
        s1  = win(c, 0);
        s2  = (c < 16) ? 0 : win(c - 16, 1);
        mux = (1 << ((n % 16) + 1)) - 1;
        pe  = rdy_pe[n];
        rdy = '0; vx = '0; vy = '0;
        if (pe >= 0) begin
            rdy[pe] = 1'b1;
            vx = 4'(pe);
            vy = 4'(rdy_y[n]);
        end
        return {1'b1, 1'b0, 8'(n % 256), 10'(s1), 10'(s2), 16'(mux),
                nd_tab[n], rdy, (n > 256), vx, vy};
    endfunction

    function automatic vec_t observe();
        return {bus.busy, bus.done, bus.AddressR, bus.AddressS1, bus.AddressS2,
                bus.S1S2mux, bus.newDist, bus.PEready, bus.CompStart,
                bus.vectorX, bus.vectorY};
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        vec_t obs;
        reset = 1'b1;
        bus.start = 1'b0;
`ifdef ME_ABORT_EN
        bus.abort = 1'b0;
`endif
        cyc();
        cyc();
        obs = observe();
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_state got %h want 0", obs);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            obs = observe();
            vectors++;
            if (obs !== '0) begin
                miscompares++;
                $display("FAIL idle_%0d got %h want 0", i, obs);
            end
        end
    endtask

    // One complete sweep with random start noise (must be ignored).
    task automatic test_sweep(input int tag);
        vec_t obs, exp;
        int   pulses, gap;
        gap = int'($urandom_range(0, 3));
        for (int i = 0; i < gap; i++) cyc();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        pulses = 0;
        for (int n = 0; n < 4112; n++) begin
            obs = observe();
            exp = model(n);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL sweep%0d n=%0d got %h want %h", tag, n, obs, exp);
            end
            if (n == 0) begin
                vectors++;
                if ({bus.busy, bus.newDist, bus.AddressR, bus.AddressS1} !== {1'b1, 16'h0001, 8'h00, 10'h000}) begin
                    miscompares++;
                    $display("FAIL first_cycle got %b/%h/%h/%h want 1/0001/00/000",
                             bus.busy, bus.newDist, bus.AddressR, bus.AddressS1);
                end
            end
            if (n == 17) begin
                vectors++;
                if ({bus.AddressS1, bus.AddressS2, bus.S1S2mux} !== {10'h021, 10'h011, 16'h0003}) begin
                    miscompares++;
                    $display("FAIL count17 got %h/%h/%h want 021/011/0003",
                             bus.AddressS1, bus.AddressS2, bus.S1S2mux);
                end
            end
            if (n == 256 || n == 257 || n == 4111) begin
                vectors++;
                if (n == 256 && {bus.PEready, bus.CompStart, bus.vectorX, bus.vectorY} !== {16'h0001, 1'b0, 4'd0, 4'd0}) begin
                    miscompares++;
                    $display("FAIL first_result got %h/%b/%0d/%0d want 0001/0/0/0",
                             bus.PEready, bus.CompStart, bus.vectorX, bus.vectorY);
                end
                if (n == 257 && {bus.PEready, bus.CompStart, bus.vectorX, bus.vectorY} !== {16'h0002, 1'b1, 4'd1, 4'd0}) begin
                    miscompares++;
                    $display("FAIL second_result got %h/%b/%0d/%0d want 0002/1/1/0",
                             bus.PEready, bus.CompStart, bus.vectorX, bus.vectorY);
                end
                if (n == 4111 && {bus.PEready, bus.vectorX, bus.vectorY} !== {16'h8000, 4'd15, 4'd15}) begin
                    miscompares++;
                    $display("FAIL last_result got %h/%0d/%0d want 8000/15/15",
                             bus.PEready, bus.vectorX, bus.vectorY);
                end
            end
            if (bus.PEready !== 16'h0000) pulses++;
            bus.start = ($urandom_range(0, 7) == 0);
            cyc();
        end
        vectors++;
        if ({bus.busy, bus.done, bus.PEready, bus.CompStart} !== {1'b0, 1'b1, 16'h0000, 1'b1}) begin
            miscompares++;
            $display("FAIL done_cycle got busy=%b done=%b rdy=%h cs=%b want 0/1/0000/1",
                     bus.busy, bus.done, bus.PEready, bus.CompStart);
        end
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        obs = observe();
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL after_done got %h want 0", obs);
        end
        vectors++;
        if (pulses != 256) begin
            miscompares++;
            $display("FAIL ready_pulses got %0d want 256", pulses);
        end
    endtask

    // Reset at sweep count k, then confirm a fresh start begins at count 0.
    task automatic test_reset_midrun(input int k);
        vec_t obs, exp;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        for (int n = 0; n < k; n++) cyc();
        obs = observe();
        exp = model(k);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL pre_reset k=%0d got %h want %h", k, obs, exp);
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        obs = observe();
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL midrun_reset k=%0d got %h want 0", k, obs);
        end
        cyc();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        for (int n = 0; n < 2; n++) begin
            obs = observe();
            exp = model(n);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL restart n=%0d got %h want %h", n, obs, exp);
            end
            cyc();
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

`ifdef ME_ABORT_EN
    task automatic test_abort(input int k);
        vec_t obs;
        int   dones;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        for (int n = 0; n < k; n++) cyc();
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        obs = observe();
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL abort k=%0d got %h want 0", k, obs);
        end
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.done !== 1'b0) dones++;
            cyc();
        end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("FAIL abort_done k=%0d got %0d pulses want 0", k, dones);
        end
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        obs = observe();
        vectors++;
        if (obs !== model(0)) begin
            miscompares++;
            $display("FAIL abort_restart got %h want %h", obs, model(0));
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask
`endif

    initial begin
        build_tables();
        test_reset();
        test_sweep(0);
        test_reset_midrun(1000);
        test_reset_midrun(int'($urandom_range(300, 3900)));
`ifdef ME_ABORT_EN
        test_abort(1000);
        test_abort(4111);
`endif
        test_sweep(1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
